// File: rtl/argmax_seq.sv
// argmax_seq: streaming argmax over NUM_CLASS class scores.
//
// An inference begins with a start pulse in IDLE. Score beats are then accepted
// in ACCUM (beat k is class k). The running best score and its index are kept,
// and ties keep the lower index. The inference ends on in_last or on beat
// NUM_CLASS-1, whichever comes first. The registered result is then presented
// in DONE until out_ready. If the beat count does not match NUM_CLASS, err is
// set and result is all ones.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   start            begin an inference (only honoured in IDLE)
//   in_valid/in_ready/in_score/in_last   score beat stream
//   out_valid/out_ready                  result handshake
//   result, max_score, err               registered inference result
//   busy             FSM is not IDLE
//
// state | meaning
// IDLE  | waiting for start, no beats accepted
// ACCUM | accepting score beats, tracking running best
// DONE  | result presented, waiting for out_ready
module argmax_seq #(
  parameter int NUM_CLASS = 10,
  parameter int DATA_W    = 32,
  parameter int IDX_W     = 4,
  parameter int SIGNED    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_score,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDX_W-1:0]  result,
  output logic [DATA_W-1:0] max_score,
  output logic              err,
  output logic              busy
);

  // The index field must also hold the all-ones error code, so it needs
  // strictly more codes than there are classes.
  if ((2**IDX_W) <= NUM_CLASS || NUM_CLASS < 2 || DATA_W < 2) begin : g_param_check
    $error("argmax_seq: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [IDX_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  best_idx_q;
  logic [DATA_W-1:0] best_q;
  logic              out_valid_q;
  logic              err_q;
  logic [IDX_W-1:0]  result_q;
  logic [DATA_W-1:0] max_q;

  logic              beat;
  logic              at_final;
  logic              term;
  logic              greater;
  logic              take;
  logic              term_err;
  logic [DATA_W-1:0] best_nxt;
  logic [IDX_W-1:0]  idx_nxt;

  assign beat     = (state_q == ACCUM) && in_valid;
  assign at_final = (cnt_q == IDX_W'(NUM_CLASS - 1));
  assign term     = beat && (in_last || at_final);
  assign term_err = !(in_last && at_final);

  assign greater  = (SIGNED != 0) ? ($signed(in_score) > $signed(best_q))
                                  : (in_score > best_q);
  // Beat 0 always seeds the best; afterwards only a strictly greater score wins.
  assign take     = (cnt_q == '0) || greater;
  assign best_nxt = take ? in_score : best_q;
  assign idx_nxt  = take ? cnt_q : best_idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b1;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) state_d = ACCUM;
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (term) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      best_idx_q  <= '0;
      best_q      <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      result_q    <= '0;
      max_q       <= '0;
    end else begin
      if (state_q == IDLE && start) begin
        cnt_q      <= '0;
        best_idx_q <= '0;
        best_q     <= '0;
      end else if (beat) begin
        cnt_q      <= cnt_q + 1'b1;
        best_idx_q <= idx_nxt;
        best_q     <= best_nxt;
      end

      // Results capture the best including the terminating beat itself.
      if (term) begin
        out_valid_q <= 1'b1;
        err_q       <= term_err;
        result_q    <= term_err ? '1 : idx_nxt;
        max_q       <= best_nxt;
      end else if (state_q == DONE && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign err       = err_q;
  assign result    = result_q;
  assign max_score = max_q;

endmodule

// File: tb/tb_argmax_seq.sv
// Self-checking bench for argmax_seq. Two instances share the stimulus: one
// compares unsigned (SIGNED=0) and one compares signed (SIGNED=1). Expected
// results are pushed to a scoreboard queue when a vector is driven. They are
// popped and compared one cycle after the terminating beat.
module tb_argmax_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [31:0] in_score;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_u, out_valid_u, err_u, busy_u;
  logic [3:0]  result_u;
  logic [31:0] max_u;
  logic        in_ready_s, out_valid_s, err_s, busy_s;
  logic [3:0]  result_s;
  logic [31:0] max_s;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  argmax_seq #(.NUM_CLASS(10), .DATA_W(32), .IDX_W(4), .SIGNED(0)) dut_u (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_u),
    .in_score(in_score), .in_last(in_last), .out_valid(out_valid_u), .out_ready(out_ready),
    .result(result_u), .max_score(max_u), .err(err_u), .busy(busy_u)
  );

  argmax_seq #(.NUM_CLASS(10), .DATA_W(32), .IDX_W(4), .SIGNED(1)) dut_s (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_score(in_score), .in_last(in_last), .out_valid(out_valid_s), .out_ready(out_ready),
    .result(result_s), .max_score(max_s), .err(err_s), .busy(busy_s)
  );

  typedef struct packed {
    logic [3:0]  ru;
    logic [31:0] mu;
    logic        eu;
    logic [3:0]  rs;
    logic [31:0] ms;
    logic        es;
  } exp_t;

  typedef struct packed {
    logic [0:9][31:0] s;
    logic             has_last;
    logic [3:0]       last_idx;
    exp_t             e;
  } vec_t;

  vec_t vq[$];
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic [0:9][31:0] s, input logic hl, input logic [3:0] li,
                         input logic [3:0] ru, input logic [31:0] mu, input logic eu,
                         input logic [3:0] rs, input logic [31:0] ms, input logic es);
    vec_t v;
    v.s = s;
    v.has_last = hl;
    v.last_idx = li;
    v.e = '{ru: ru, mu: mu, eu: eu, rs: rs, ms: ms, es: es};
    vq.push_back(v);
  endtask

  // Reference argmax for both compare modes.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int term;
    logic [31:0] bu, bs;
    int iu, is;
    term = (v.has_last && v.last_idx < 9) ? int'(v.last_idx) : 9;
    bu = v.s[0]; bs = v.s[0]; iu = 0; is = 0;
    for (int k = 1; k <= term; k++) begin
      if (v.s[k] > bu) begin bu = v.s[k]; iu = k; end
      if ($signed(v.s[k]) > $signed(bs)) begin bs = v.s[k]; is = k; end
    end
    e.eu = !(v.has_last && term == 9 && v.last_idx == 9);
    e.es = e.eu;
    e.mu = bu;
    e.ms = bs;
    e.ru = e.eu ? 4'hF : 4'(iu);
    e.rs = e.es ? 4'hF : 4'(is);
    return e;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ov_u"}, out_valid_u, 0);  chk({tag, "_ov_s"}, out_valid_s, 0);
    chk({tag, "_rdy_u"}, in_ready_u, 0);  chk({tag, "_rdy_s"}, in_ready_s, 0);
    chk({tag, "_res_u"}, result_u, 0);    chk({tag, "_res_s"}, result_s, 0);
    chk({tag, "_max_u"}, max_u, 0);       chk({tag, "_max_s"}, max_s, 0);
    chk({tag, "_err_u"}, err_u, 0);       chk({tag, "_err_s"}, err_s, 0);
    chk({tag, "_busy_u"}, busy_u, 0);     chk({tag, "_busy_s"}, busy_s, 0);
  endtask

  task automatic chk_result(input string tag, input exp_t e);
    chk({tag, "_ov_u"}, out_valid_u, 1);  chk({tag, "_ov_s"}, out_valid_s, 1);
    chk({tag, "_res_u"}, result_u, e.ru); chk({tag, "_res_s"}, result_s, e.rs);
    chk({tag, "_max_u"}, max_u, e.mu);    chk({tag, "_max_s"}, max_s, e.ms);
    chk({tag, "_err_u"}, err_u, e.eu);    chk({tag, "_err_s"}, err_s, e.es);
    chk({tag, "_rdy_u"}, in_ready_u, 0);  chk({tag, "_rdy_s"}, in_ready_s, 0);
  endtask

  // mode 0: normal release, 1: hold in DONE with start pulses, 2: reset in DONE
  task automatic run_vec(input vec_t v, input int mode, input string tag);
    int term;
    exp_t e;
    term = (v.has_last && v.last_idx < 9) ? int'(v.last_idx) : 9;
    exp_q.push_back(v.e);
    tick;
    // A beat presented alongside start must not be taken.
    start = 1; in_valid = 1; in_score = 32'h7FFF_FFFF; in_last = 1;
    tick;
    start = 0; in_valid = 0; in_last = 0;
    chk({tag, "_accum_rdy"}, in_ready_u, 1);
    chk({tag, "_accum_busy"}, busy_s, 1);
    for (int k = 0; k <= term; k++) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 0;
        tick;
      end
      in_valid = 1;
      in_score = v.s[k];
      in_last  = v.has_last && (4'(k) == v.last_idx);
      chk({tag, "_early_ov"}, out_valid_u | out_valid_s, 0);
      tick;
    end
    in_valid = 0; in_last = 0;
    e = exp_q.pop_front();
    chk_result(tag, e);
    if (mode == 1) begin
      for (int c = 0; c < 5; c++) begin
        start = (c % 2 == 0);
        tick;
        chk_result({tag, "_hold"}, e);
        chk({tag, "_hold_busy"}, busy_u, 1);
      end
      start = 0;
    end
    if (mode == 2) begin
      rst = 1; out_ready = 0;
      tick;
      rst = 0;
      chk_reset_outputs({tag, "_rst_done"});
    end else begin
      out_ready = 1;
      tick;
      out_ready = 0;
      chk({tag, "_rel_ov_u"}, out_valid_u, 0);
      chk({tag, "_rel_ov_s"}, out_valid_s, 0);
      chk({tag, "_rel_busy"}, busy_u | busy_s, 0);
    end
  endtask

  initial begin
    vec_t v;
    rst = 1; start = 0; in_valid = 0; in_score = '0; in_last = 0; out_ready = 0;
    tick;
    tick;
    chk_reset_outputs("reset");
    rst = 0;

    // nominal
    add_vec({32'd5, 32'd9, 32'd3, 32'd12, 32'd40, 32'd7, 32'd8, 32'd100, 32'd2, 32'd60},
            1, 9, 4'd7, 32'd100, 0, 4'd7, 32'd100, 0);
    // tie at 2 and 6
    add_vec({32'd10, 32'd20, 32'd50, 32'd30, 32'd40, 32'd1, 32'd50, 32'd2, 32'd3, 32'd4},
            1, 9, 4'd2, 32'd50, 0, 4'd2, 32'd50, 0);
    // sign bit set on beat 3
    add_vec({32'd1, 32'd2, 32'd3, 32'h8000_0000, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9},
            1, 9, 4'd3, 32'h8000_0000, 0, 4'd9, 32'd9, 0);
    // in_last early on beat 4
    add_vec({32'd5, 32'd9, 32'd3, 32'd12, 32'd40, 32'd7, 32'd8, 32'd100, 32'd2, 32'd60},
            1, 4, 4'hF, 32'd40, 1, 4'hF, 32'd40, 1);
    // no in_last by beat 9
    add_vec({32'd5, 32'd9, 32'd3, 32'd12, 32'd40, 32'd7, 32'd8, 32'd100, 32'd2, 32'd60},
            0, 0, 4'hF, 32'd100, 1, 4'hF, 32'd100, 1);
    // negative values split the two modes
    add_vec({32'd100, 32'hFFFF_FFFF, 32'd50, 32'd7, 32'hFFFF_FFFE, 32'd3, 32'd99, 32'd0, 32'd1, 32'd2},
            1, 9, 4'd1, 32'hFFFF_FFFF, 0, 4'd0, 32'd100, 0);
    // all equal keeps index 0
    add_vec({32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7, 32'd7},
            1, 9, 4'd0, 32'd7, 0, 4'd0, 32'd7, 0);
    // max on the final beat
    add_vec({32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9},
            1, 9, 4'd9, 32'd9, 0, 4'd9, 32'd9, 0);
    // in_last on beat 0
    add_vec({32'd42, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0},
            1, 0, 4'hF, 32'd42, 1, 4'hF, 32'd42, 1);

    for (int i = 0; i < vq.size(); i++) begin
      run_vec(vq[i], (i == 0) ? 1 : (i == 3) ? 2 : 0, $sformatf("vec%0d", i));
    end

    // Reset after four accepted beats, then a clean rerun of the nominal case.
    tick;
    start = 1;
    tick;
    start = 0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1;
      in_score = 32'd1000 + 32'(k);
      tick;
    end
    rst = 1; in_valid = 1; in_score = 32'hFFFF_FFFF; start = 1; out_ready = 1;
    tick;
    rst = 0; in_valid = 0; start = 0; out_ready = 0;
    chk_reset_outputs("rst_mid");
    run_vec(vq[0], 0, "post_rst");

    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 10; k++) begin
        v.s[k] = (r % 2 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      end
      v.has_last = 1;
      v.last_idx = 4'd9;
      v.e = model(v);
      run_vec(v, 0, $sformatf("rand%0d", r));
    end

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/argmax_seq.md
ARGMAX_SEQ -- requirements
Module: argmax_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameters SHALL be (name, default, meaning):
- NUM_CLASS, 10, number of class scores per inference.
- DATA_W, 32, score width.
- IDX_W, 4, class index width.
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned compare.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- start, in, 1, single-cycle pulse that begins an inference.
- in_valid, in, 1, score beat valid.
- in_ready, out, 1, block accepts a score beat.
- in_score, in, DATA_W, class score; beat k is class k.
- in_last, in, 1, marks the final beat.
- out_valid, out, 1, result available.
- out_ready, in, 1, consumer accepts the result.
- result, out, IDX_W, winning class index.
- max_score, out, DATA_W, winning score.
- err, out, 1, beat-count mismatch flag.
- busy, out, 1, high when the FSM is not IDLE.
REQ-004 Elaboration SHALL fail if 2**IDX_W <= NUM_CLASS, if NUM_CLASS < 2, or if DATA_W < 2.

Function
REQ-005 The FSM SHALL have three states: IDLE, ACCUM and DONE.
REQ-006 IDLE behaviour:
- in_ready=0 and out_valid=0.
- start=1 SHALL move the FSM to ACCUM and clear the beat counter, best_idx and best score.
REQ-007 In ACCUM, in_ready SHALL be 1; a beat is accepted when in_valid && in_ready.
REQ-008 On an accepted beat with counter value k:
- If k==0, or in_score > best under the SIGNED compare mode, best SHALL take in_score and best_idx SHALL take k.
- The counter SHALL then increment.
REQ-009 Ties SHALL keep the lower index; replacement requires a strictly greater score.
REQ-010 An accepted beat SHALL end the inference and move the FSM to DONE when in_last=1 or k==NUM_CLASS-1.
- err SHALL be 0 only when in_last=1 and k==NUM_CLASS-1 on the same beat.
- Any other terminating beat SHALL set err=1.
REQ-011 out_valid, result, max_score and err SHALL be registered and SHALL assert on the cycle after the terminating beat (1-cycle latency).
REQ-012 DONE output values:
- err=0: result=best_idx and max_score=best.
- err=1: result SHALL be all ones (2**IDX_W-1) and max_score SHALL be the best score seen so far.
REQ-013 In DONE, out_valid=1 and in_ready=0; result, max_score and err SHALL hold stable until out_ready=1.
- The FSM then returns to IDLE and out_valid deasserts on the following cycle.
REQ-014 start SHALL be ignored in ACCUM and DONE; start in IDLE SHALL NOT accept a beat in the same cycle.
REQ-015 Gaps in in_valid during ACCUM SHALL stall accumulation without loss of state.
REQ-016 Compares SHALL be full DATA_W width with no truncation or saturation.

Reset
REQ-017 With rst=1 at a clock edge, the block SHALL enter IDLE and clear the counter, best, best_idx and all outputs: in_ready=0, out_valid=0, result=0, max_score=0, err=0, busy=0.
REQ-018 Reset SHALL take priority over start, beats and out_ready, including mid-ACCUM and in DONE.
- Any partial inference is discarded.

Verification
REQ-019 Nominal unsigned case:
- Stimulus: SIGNED=0; scores 5,9,3,12,40,7,8,100,2,60, with in_last on beat 9.
- Response: one cycle later out_valid=1, result=7, max_score=100, err=0.
REQ-020 Tie case:
- Stimulus: scores with a maximum of 50 at indices 2 and 6, last on beat 9.
- Response: result=2, max_score=50.
REQ-021 Signed versus unsigned compare:
- Stimulus: beat 3=0x80000000, all other beats 1..9.
- Response: SIGNED=1 gives result=9 (score 9); SIGNED=0 gives result=3.
REQ-022 Count mismatch:
- Stimulus A: in_last on beat 4. Response: err=1, result=15, max_score = best of beats 0-4.
- Stimulus B: no in_last by beat 9. Response: err=1, FSM in DONE.
REQ-023 Output hold and ignored start:
- Stimulus: out_ready held low for 5 cycles in DONE, with start pulsed.
- Response: outputs stable, in_ready=0, start ignored; out_ready=1 returns the FSM to IDLE, and out_valid=0 on the next cycle.
REQ-024 Reset mid-operation:
- Stimulus: rst=1 after 4 accepted beats.
- Response: next cycle all outputs are at reset values and busy=0.
- Follow-up: a new start followed by 10 beats produces a correct, uncorrupted result.
